// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
// Results and flags are registered and change only on the cycle that raises done.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_bad_params
      $error("WIDTH must be a non-zero integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic [SLICE:0]     slice_res;

  // Operands shift right each cycle so the active slice is always the low SLICE bits;
  // the accumulator fills from the top so slice 0 lands at bit 0 after N cycles.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    slice_res = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        slice_res = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - (SLICE+1)'(borrow_q);
        acc_d     = acc_q >> SLICE;
        acc_d[WIDTH-1 -: SLICE] = slice_res[SLICE-1:0];
        a_d       = a_q >> SLICE;
        b_d       = b_q >> SLICE;
        borrow_d  = slice_res[SLICE];
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Top slice still holds the original operand MSBs at bit SLICE-1.
          diff_d  = acc_d;
          bout_d  = slice_res[SLICE];
          ovf_d   = (a_q[SLICE-1] != b_q[SLICE-1]) && (acc_d[WIDTH-1] != a_q[SLICE-1]);
          zero_d  = (acc_d == '0);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
